// File: rtl/bitnot_check_pkg.sv
// Shared layout constants for the bit-inversion checker: where each field
// lives in the stimulus and response vectors, which mask bit reports it,
// and the capture state encoding.
package bitnot_check_pkg;

  localparam int VEC_W       = 128;
  localparam int NFIELD      = 9;    // a1..a9 / b1..b9, field k is k bits wide
  localparam int HALF_W      = 45;   // 1+2+...+9
  localparam int STIM_USED_W = 90;

  // Stimulus: b fields in the low half, a fields above them.
  localparam int STIM_B_LO   = 0;
  localparam int STIM_A_LO   = 45;

  // Response: inverted a fields low, inverted b fields above, then six
  // 6-bit derived fields and two pad bits.
  localparam int RESP_OA_LO  = 0;
  localparam int RESP_OB_LO  = 45;
  localparam int RESP_OC_LO  = 90;
  localparam int OC_W        = 6;
  localparam int NOC         = 6;
  localparam int RESP_PAD_LO = 126;
  localparam int PAD_W       = 2;

  // Mismatch mask bit positions.
  localparam int MASK_W      = 25;
  localparam int MASK_OA     = 0;
  localparam int MASK_OB     = 9;
  localparam int MASK_OC     = 18;
  localparam int MASK_PAD    = 24;

  typedef enum logic {
    CAP_EMPTY = 1'b0,
    CAP_HELD  = 1'b1
  } cap_state_t;

  // Offset of the k-bit field inside a packed half (fields 1..k-1 sit below it).
  function automatic int fld_off(input int w);
    return (w * (w - 1)) / 2;
  endfunction

endpackage

// File: rtl/bitnot_expect.sv
// Combinational model of the bit-inversion unit: turns the decoded stimulus
// into the response the unit should produce.
module bitnot_expect
  import bitnot_check_pkg::*;
(
  input  logic [STIM_USED_W-1:0] stim,
  output logic [VEC_W-1:0]       exp_resp
);

  localparam int A9_LO = fld_off(9);
  localparam int A3_LO = fld_off(3);
  localparam int A1_LO = fld_off(1);
  localparam int B3_LO = fld_off(3);
  localparam int B1_LO = fld_off(1);

  logic [HALF_W-1:0] w_a;
  logic [HALF_W-1:0] w_b;

  assign w_b = stim[STIM_B_LO +: HALF_W];
  assign w_a = stim[STIM_A_LO +: HALF_W];

  genvar gi;
  generate
    for (gi = 1; gi <= NFIELD; gi++) begin : g_fld
      localparam int OFF = fld_off(gi);
      // The a and b halves swap places in the response.
      assign exp_resp[RESP_OA_LO + OFF +: gi] = ~w_a[OFF +: gi];
      assign exp_resp[RESP_OB_LO + OFF +: gi] = ~w_b[OFF +: gi];
    end
  endgenerate

  // Derived fields; oc4 and oc6 sign-extend the signed b3/b1 values.
  assign exp_resp[RESP_OC_LO + 0*OC_W +: OC_W] = ~w_a[A9_LO +: 6];
  assign exp_resp[RESP_OC_LO + 1*OC_W +: OC_W] = ~w_a[A9_LO +: 6];
  assign exp_resp[RESP_OC_LO + 2*OC_W +: OC_W] = {3'b111, ~w_a[A3_LO +: 3]};
  assign exp_resp[RESP_OC_LO + 3*OC_W +: OC_W] = {{3{~w_b[B3_LO + 2]}}, ~w_b[B3_LO +: 3]};
  assign exp_resp[RESP_OC_LO + 4*OC_W +: OC_W] = {5'b11111, ~w_a[A1_LO]};
  assign exp_resp[RESP_OC_LO + 5*OC_W +: OC_W] = {6{~w_b[B1_LO]}};
  assign exp_resp[RESP_PAD_LO +: PAD_W]        = 2'b00;

endmodule

// File: rtl/bitnot_check.sv
// Two-stage checker for a bit-inversion unit: compares each offered
// stimulus/response pair against the expected response, reports a
// per-field mismatch mask, counts results and captures the first failure.
module bitnot_check
  import bitnot_check_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int FAIL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        stim,
  input  logic [127:0]        resp,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [24:0]         res_mask,
  input  logic                clear,
  output logic [CNT_W-1:0]    n_checked,
  output logic [FAIL_W-1:0]   n_failed,
  output logic                cap_valid,
  output logic [127:0]        cap_stim,
  output logic [127:0]        cap_resp,
  output logic [24:0]         cap_mask
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FAIL_W-1:0] FAIL_ONE = {{(FAIL_W-1){1'b0}}, 1'b1};

  logic [VEC_W-1:0]  w_exp;
  logic [MASK_W-1:0] w_s1_mask;
  logic              w_s1_adv, w_s2_adv, w_acc, w_hs, w_fail_hs, w_cap_load;

  logic              r_s1_valid;
  logic [VEC_W-1:0]  r_s1_diff, r_s1_stim, r_s1_resp;
  logic              r_s2_valid;
  logic [MASK_W-1:0] r_s2_mask;
  logic [VEC_W-1:0]  r_s2_stim, r_s2_resp;

  logic [CNT_W-1:0]  r_n_checked;
  logic [FAIL_W-1:0] r_n_failed;
  cap_state_t        r_cap_state, w_cap_next;
  logic [VEC_W-1:0]  r_cap_stim, r_cap_resp;
  logic [MASK_W-1:0] r_cap_mask;

  bitnot_expect u_expect (
    .stim     (stim[STIM_USED_W-1:0]),
    .exp_resp (w_exp)
  );

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_s2_adv  = !r_s2_valid || res_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_acc     = in_valid && in_ready;
  assign w_hs      = r_s2_valid && res_ready;
  assign w_fail_hs = w_hs && (r_s2_mask != '0);

  // Per-field OR-reduce of the registered difference.
  genvar gi;
  generate
    for (gi = 1; gi <= NFIELD; gi++) begin : g_red_ab
      assign w_s1_mask[MASK_OA + gi - 1] = |r_s1_diff[RESP_OA_LO + fld_off(gi) +: gi];
      assign w_s1_mask[MASK_OB + gi - 1] = |r_s1_diff[RESP_OB_LO + fld_off(gi) +: gi];
    end
    for (gi = 0; gi < NOC; gi++) begin : g_red_oc
      assign w_s1_mask[MASK_OC + gi] = |r_s1_diff[RESP_OC_LO + gi*OC_W +: OC_W];
    end
  endgenerate
  assign w_s1_mask[MASK_PAD] = |r_s1_diff[RESP_PAD_LO +: PAD_W];

  // Pipeline: S1 holds expected^resp, S2 holds the mask; both stall on backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
      r_s1_stim  <= '0;
      r_s1_resp  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mask  <= '0;
      r_s2_stim  <= '0;
      r_s2_resp  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_acc;
        r_s1_diff  <= w_exp ^ resp;
        r_s1_stim  <= stim;
        r_s1_resp  <= resp;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_mask  <= w_s1_mask;
        r_s2_stim  <= r_s1_stim;
        r_s2_resp  <= r_s1_resp;
      end
    end
  end

  // Saturating result counters; clear beats a coincident handshake.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_n_checked <= '0;
      r_n_failed  <= '0;
    end else if (w_hs) begin
      if (r_n_checked != '1) r_n_checked <= r_n_checked + CNT_ONE;
      if (w_fail_hs && (r_n_failed != '1)) r_n_failed <= r_n_failed + FAIL_ONE;
    end
  end

  // Capture state register.
  always_ff @(posedge clk) begin
    if (rst) r_cap_state <= CAP_EMPTY;
    else     r_cap_state <= w_cap_next;
  end

  // Capture next state: first failing result latches, clear re-arms.
  always_comb begin
    w_cap_next = r_cap_state;
    case (r_cap_state)
      CAP_EMPTY: if (w_fail_hs) w_cap_next = CAP_HELD;
      CAP_HELD:  w_cap_next = CAP_HELD;
      default:   w_cap_next = CAP_EMPTY;
    endcase
    if (clear) w_cap_next = CAP_EMPTY;
  end

  // Capture outputs decoded from state.
  always_comb begin
    cap_valid = (r_cap_state == CAP_HELD);
  end

  assign w_cap_load = (r_cap_state == CAP_EMPTY) && w_fail_hs && !clear;

  // Captured pair data, loaded together with the EMPTY->HELD transition.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cap_stim <= '0;
      r_cap_resp <= '0;
      r_cap_mask <= '0;
    end else if (w_cap_load) begin
      r_cap_stim <= r_s2_stim;
      r_cap_resp <= r_s2_resp;
      r_cap_mask <= r_s2_mask;
    end
  end

  assign res_valid = r_s2_valid;
  assign res_mask  = r_s2_mask;
  assign n_checked = r_n_checked;
  assign n_failed  = r_n_failed;
  assign cap_stim  = r_cap_stim;
  assign cap_resp  = r_cap_resp;
  assign cap_mask  = r_cap_mask;

endmodule

// File: doc/bitnot_check.md
BITNOT_CHECK -- requirements
Module: bitnot_check

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of checked-vector counter.
REQ-002 SHALL have parameter FAIL_W, default 16, width of failure counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  stimulus/response pair offered.
REQ-006 in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-007 stim  input  128  stimulus vector as applied to the bit-inversion unit.
REQ-008 resp  input  128  response vector produced by the bit-inversion unit.
REQ-009 res_valid  output  1  per-pair result available.
REQ-010 res_ready  input  1  result consumed when res_valid && res_ready.
REQ-011 res_mask  output  25  per-field mismatch mask; bit 24 = pad bits resp[127:126].
REQ-012 clear  input  1  synchronous clear of counters and capture; pipeline untouched.
REQ-013 n_checked  output  CNT_W  pairs retired, saturating.
REQ-014 n_failed  output  FAIL_W  retired pairs with nonzero mask, saturating.
REQ-015 cap_valid  output  1  first failure captured.
REQ-016 cap_stim, cap_resp  output  128 each  stim/resp of first failing pair.
REQ-017 cap_mask  output  25  mask of first failing pair.

Function
REQ-018 Stim decode SHALL be: low 90 bits = {a9,a8,a7,a6,a5,a4,a3,a2,a1,b9,...,b1}, widths 9..1, b1 at bit 0; stim[127:90] ignored; b fields signed.
REQ-019 Expected resp SHALL be: [44:0]={~a9..~a1}, oa1 at bit 0; [89:45]={~b9..~b1}; [95:90]=~a9[5:0]; [101:96]=~a9[5:0]; [107:102]={3'b111,~a3}; [113:108]={3{~b3[2]},~b3}; [119:114]={5'b11111,~a1}; [125:120]={6{~b1}}; [127:126]=0.
REQ-020 Mask bits 0..8 SHALL be oa1..oa9, 9..17 ob1..ob9, 18..23 oc1..oc6, 24 pad; bit set iff any bit in that field differs.
REQ-021 Pipeline SHALL be 2 stages (S1: expected + XOR registered; S2: field OR-reduce registered); an accepted pair SHALL appear on res_valid exactly 2 cycles later absent backpressure.
REQ-022 Throughput SHALL be one pair per cycle when res_ready held high.
REQ-023 in_ready SHALL be low only when S2 holds valid unconsumed result and S1 also full; no pair lost or duplicated under any res_ready pattern.
REQ-024 res_mask and res_valid SHALL remain stable while res_valid && !res_ready.
REQ-025 n_checked/n_failed SHALL increment on result handshake, not on acceptance; each saturates at all-ones.
REQ-026 Capture FSM: states EMPTY, HELD; EMPTY->HELD on handshake of a pair with nonzero mask, loading cap_*; HELD ignores further failures; clear -> EMPTY.
REQ-027 clear coincident with a result handshake SHALL win: counters read 0 next cycle, capture EMPTY.
REQ-028 X/Z in resp SHALL NOT be specially detected (2-state comparison).

Reset
REQ-029 On rst: in_ready=1, res_valid=0, res_mask=0, n_checked=0, n_failed=0, cap_valid=0 (FSM EMPTY), cap_stim=0, cap_resp=0, cap_mask=0.
REQ-030 rst mid-operation SHALL discard all in-flight pairs; no result emitted for them.
REQ-031 rst SHALL dominate clear.

Structure
REQ-032 Package bitnot_check_pkg SHALL hold field offset/width constants, mask bit indices, and capture-state enum.
REQ-033 Sub-module bitnot_expect SHALL be the combinational stim-to-expected-resp generator; bitnot_check instantiates it in S1.

Verification
REQ-034 stim=0, resp=128'h3FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF -> mask 0, n_checked=1, n_failed=0, cap_valid=0.
REQ-035 stim=128'h1 (b1=1), correct resp has [125:120]=0, [45]=0 -> mask 0; flip resp[120] -> mask bit 23 only, cap_valid=1.
REQ-036 stim with b3=3'b100 (bit 3), resp[113:108]=6'b000011 -> mask 0; 6'b111011 -> mask bit 21.
REQ-037 Back-to-back 10 pairs, res_ready toggling 1/0 each cycle -> 10 results in order, masks match, n_checked=10.
REQ-038 Two failing pairs then clear then one failing pair -> cap holds third pair, n_failed=1.
REQ-039 rst asserted with 2 pairs in flight -> res_valid=0 next cycle, counters 0, no result appears.
